// File: rtl/bram_pkg.sv
// Shared constants, FSM state type and the byte-enable merge helper for bram_tdp_init.
package bram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MAX_DW = 1024;
    localparam int MAX_NB = MAX_DW;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // Bit j takes the new value when the enable of its byte (j / bw) is set.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NB-1:0] we,
        input int                bw
    );
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int j = 0; j < MAX_DW; j++) begin
            if (we[j / bw]) r[j] = new_w[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_port_pipe.sv
// Per-port read pipeline: read-data register(s) and the rvalid shift.
module bram_port_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [READ_LAT:1]     vld_pipe;
    logic [DATA_WIDTH-1:0] d1;

    // First data stage: captures the selected word, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       d1 <= '0;
        else if (load) d1 <= din;
    end

    if (READ_LAT == 1) begin : g_lat1
        // Single-stage valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_pipe <= '0;
            else     vld_pipe <= acc;
        end
        assign rdata = d1;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] d2;
        // Output register stage: free-running copy of stage 1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_pipe <= '0;
                d2       <= '0;
            end else begin
                vld_pipe <= {vld_pipe[1], acc};
                d2       <= d1;
            end
        end
        assign rdata = d2;
    end

    assign rvalid = vld_pipe[READ_LAT];

endmodule

// File: rtl/bram_tdp_init.sv
// True-dual-port RAM with byte enables, hardware clear sequencer and defined collision rules.
module bram_tdp_init
    import bram_pkg::*;
#(
    parameter int                                ADDR_WIDTH = 10,
    parameter int                                DATA_WIDTH = 64,
    parameter int                                BYTE_WIDTH = 8,
    parameter int                                READ_LAT   = 1,
    parameter int                                WRITE_MODE = 0,
    parameter logic [DATA_WIDTH-1:0]             INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            wdata_a,
    output logic [DATA_WIDTH-1:0]            rdata_a,
    output logic                             rvalid_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            wdata_b,
    output logic [DATA_WIDTH-1:0]            rdata_b,
    output logic                             rvalid_b
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_bw
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_chk_lat
        $error("READ_LAT must be 1 or 2");
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_chk_wm
        $error("WRITE_MODE must be 0, 1 or 2");
    end

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] o,
        input logic [DATA_WIDTH-1:0] n,
        input logic [NB-1:0]         we
    );
        logic [MAX_DW-1:0] wo, wn, wr;
        logic [MAX_NB-1:0] ww;
        wo = '0; wn = '0; ww = '0;
        wo[DATA_WIDTH-1:0] = o;
        wn[DATA_WIDTH-1:0] = n;
        ww[NB-1:0]         = we;
        wr = byte_merge(wo, wn, ww, BYTE_WIDTH);
        return wr[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;

    logic                  acc_a, acc_b, wr_a, wr_b, load_a, load_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, own_a, own_b, store_a, din_a, din_b;

    // Clear FSM state and address counter; reset restarts clearing from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) cnt <= cnt + 1'b1;
        end
    end

    // Next state: leave CLEAR after the write to the last address.
    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        if (state == ST_CLEAR) begin
            init_busy = 1'b1;
            if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_READY;
        end
    end

    // Access decode, merges and per-port read-data selection.
    always_comb begin
        acc_a = en_a && (state == ST_READY);
        acc_b = en_b && (state == ST_READY);
        wr_a  = acc_a && (|we_a);
        wr_b  = acc_b && (|we_b);
        old_a = mem[addr_a];
        old_b = mem[addr_b];
        own_a = merge(old_a, wdata_a, we_a);
        own_b = merge(old_b, wdata_b, we_b);
        // Both writing one word: A's bytes are layered over B's merged word.
        store_a = (wr_b && addr_a == addr_b) ? merge(own_b, wdata_a, we_a) : own_a;
        // Only a same-port write can return new data; a cross-port reader sees old.
        din_a  = (wr_a && WRITE_MODE == WM_WRITE_FIRST) ? own_a : old_a;
        din_b  = (wr_b && WRITE_MODE == WM_WRITE_FIRST) ? own_b : old_b;
        load_a = acc_a && !(wr_a && WRITE_MODE == WM_NO_CHANGE);
        load_b = acc_b && !(wr_b && WRITE_MODE == WM_NO_CHANGE);
    end

    // Memory writes: clear sequencer owns the array until READY; A is applied last so it wins.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= INIT_VALUE;
        end else begin
            if (wr_b) mem[addr_b] <= own_b;
            if (wr_a) mem[addr_a] <= store_a;
        end
    end

    bram_port_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LAT(READ_LAT)) u_pipe_a (
        .clk(clk), .rst(rst), .acc(acc_a), .load(load_a), .din(din_a),
        .rdata(rdata_a), .rvalid(rvalid_a)
    );

    bram_port_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LAT(READ_LAT)) u_pipe_b (
        .clk(clk), .rst(rst), .acc(acc_b), .load(load_b), .din(din_b),
        .rdata(rdata_b), .rvalid(rvalid_b)
    );

endmodule
